// File: rtl/ibex_pkg.sv
// ibex_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   mem_src_e      : identifies which requester owns a host transaction.
//   MemInstrBe     : byte enables presented to the host for instruction fetches.
//   MemInstrWdata  : write data presented to the host for instruction fetches.
//   mem_src_other  : returns the opposite requester (used by round-robin).
package ibex_pkg;

    typedef enum logic {
        MemSrcInstr = 1'b0,
        MemSrcData  = 1'b1
    } mem_src_e;

    // Instruction fetches are always full-word reads.
    localparam logic [3:0]  MemInstrBe    = 4'hF;
    localparam logic [31:0] MemInstrWdata = 32'h0;

    function automatic mem_src_e mem_src_other(input mem_src_e src);
        return (src == MemSrcData) ? MemSrcInstr : MemSrcData;
    endfunction

endpackage

// File: rtl/ibex_mem_src_fifo.sv
// ibex_mem_src_fifo
// In-order FIFO remembering which requester owns each granted-but-unanswered
// host transaction. Built from flops only (Depth is at most 4).
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset, empties the FIFO
//   push_i      : store push_src_i at the tail (ignored when full)
//   push_src_i  : source ID to store
//   pop_i       : discard the head entry (ignored when empty)
//   full_o      : Depth entries held
//   empty_o     : no entries held
//   head_o      : source ID of the oldest entry
module ibex_mem_src_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  mem_src_e push_src_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output mem_src_e head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    mem_src_e        slots_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_en;
    logic            pop_en;

    // Pointers wrap at Depth rather than at a power of two, so odd depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (cnt_q == DepthCnt);
    assign empty_o = (cnt_q == '0);
    assign head_o  = slots_q[rd_ptr_q];

    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                slots_q[i] <= MemSrcInstr;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_en) begin
                slots_q[wr_ptr_q] <= push_src_i;
            end
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
// Shares one ibex-protocol host memory port between the instruction-fetch and
// data requesters with no added latency: request and response paths are
// combinational, only arbitration bookkeeping is registered.
// Ports:
//   clk_i, rst_i                 : clock and synchronous active-high reset
//   instr_*                      : instruction requester (read-only)
//   data_*                       : data requester (read/write)
//   mem_*                        : host memory port
//   protocol_err_o               : sticky, set by a host response arriving
//                                  while nothing is outstanding
// Parameters:
//   MaxOutstanding (1..4)        : granted-but-unanswered host transactions
//   DataFirstReset               : requester favoured after reset (1 = data)
module ibex_mem_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter logic        DataFirstReset = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        protocol_err_o
);

    mem_src_e sel_src;
    mem_src_e rr_q, rr_d;
    mem_src_e lock_src_q, lock_src_d;
    mem_src_e head_src;
    logic     lock_q, lock_d;
    logic     proto_err_q, proto_err_d;
    logic     sel_req;
    logic     sel_is_data;
    logic     fifo_full;
    logic     fifo_empty;
    logic     host_gnt;
    logic     resp_pop;
    logic     resp_stray;

    // Requester selection. A request left waiting on the host keeps its slot
    // so the host sees stable req/addr/we/be/wdata until it grants; otherwise
    // a lone requester wins and a tie goes to the round-robin favourite.
    always_comb begin
        sel_src = MemSrcInstr;
        if (lock_q) begin
            sel_src = lock_src_q;
        end else if (instr_req_i && data_req_i) begin
            sel_src = rr_q;
        end else if (data_req_i) begin
            sel_src = MemSrcData;
        end
    end

    assign sel_is_data = (sel_src == MemSrcData);
    assign sel_req     = sel_is_data ? data_req_i : instr_req_i;

    // A full source FIFO blocks new requests even if a response frees a slot
    // in the same cycle; this keeps mem_rvalid_i out of the mem_req_o path.
    assign mem_req_o = sel_req & ~fifo_full & ~rst_i;
    assign host_gnt  = mem_gnt_i & mem_req_o;

    assign mem_addr_o  = sel_is_data ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = sel_is_data ? data_we_i    : 1'b0;
    assign mem_be_o    = sel_is_data ? data_be_i    : MemInstrBe;
    assign mem_wdata_o = sel_is_data ? data_wdata_i : MemInstrWdata;

    assign instr_gnt_o = host_gnt & ~sel_is_data;
    assign data_gnt_o  = host_gnt & sel_is_data;

    // Responses return in grant order, so the FIFO head names their owner.
    // A response with nothing outstanding is dropped and flagged instead.
    assign resp_pop   = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign resp_stray = mem_rvalid_i & fifo_empty & ~rst_i;

    assign instr_rvalid_o = resp_pop & (head_src == MemSrcInstr);
    assign data_rvalid_o  = resp_pop & (head_src == MemSrcData);
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign protocol_err_o = proto_err_q & ~rst_i;

    ibex_mem_src_fifo #(
        .Depth (MaxOutstanding)
    ) u_src_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (host_gnt),
        .push_src_i (sel_src),
        .pop_i      (resp_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head_src)
    );

    // Bookkeeping: the round-robin favourite flips away from whoever was just
    // granted, and the lock is taken whenever a request goes unanswered by
    // the host and released by the grant.
    always_comb begin
        rr_d        = rr_q;
        lock_d      = lock_q;
        lock_src_d  = lock_src_q;
        proto_err_d = proto_err_q | resp_stray;
        if (host_gnt) begin
            rr_d   = mem_src_other(sel_src);
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            lock_d     = 1'b1;
            lock_src_d = sel_src;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= mem_src_e'(DataFirstReset);
            lock_q      <= 1'b0;
            lock_src_q  <= MemSrcInstr;
            proto_err_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            lock_src_q  <= lock_src_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: doc/ibex_mem_arbiter.md
IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, maximum granted-but-unanswered host transactions (legal range 1..4).
REQ-002 SHALL have parameter DataFirstReset, default 1'b1, requester favoured by round-robin after reset (1 = data).
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have instr ports: instr_req_i in 1, instr_gnt_o out 1, instr_rvalid_o out 1, instr_addr_i in 32, instr_rdata_o out 32, instr_err_o out 1.
REQ-006 SHALL have data ports: data_req_i in 1, data_gnt_o out 1, data_rvalid_o out 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32, data_rdata_o out 32, data_err_o out 1.
REQ-007 SHALL have host ports: mem_req_o out 1, mem_gnt_i in 1, mem_rvalid_i in 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_rdata_i in 32, mem_err_i in 1.
REQ-008 SHALL have port protocol_err_o  out  1  sticky flag: mem_rvalid_i seen with no outstanding transaction.

Function
REQ-009 SHALL share one host port between instr and data requesters using ibex req/gnt/rvalid protocol, zero added latency (combinational request and response paths).
REQ-010 SHALL select requester: only one requesting -> that one; both -> round-robin, favouring the one not most recently granted.
REQ-011 SHALL lock selection once mem_req_o asserted without mem_gnt_i; lock held until grant, so host sees stable req/addr/we/be/wdata.
REQ-012 SHALL drive mem_req_o = selected req AND NOT fifo_full; full masks mem_req_o even if mem_rvalid_i pops in the same cycle.
REQ-013 SHALL drive instr transactions as mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0; data transactions pass data_we_i/be/wdata through.
REQ-014 SHALL drive instr_gnt_o/data_gnt_o = mem_gnt_i AND mem_req_o AND selected source; never both in one cycle.
REQ-015 SHALL push granted source ID into an in-order source FIFO of depth MaxOutstanding on each host grant.
REQ-016 SHALL on mem_rvalid_i with FIFO non-empty pop head and route rvalid, rdata, err to that source only; other rvalid 0.
REQ-017 SHALL permit push and pop in the same cycle when FIFO not full; count unchanged.
REQ-018 SHALL on mem_rvalid_i with FIFO empty drop response (no requester rvalid) and set protocol_err_o until reset.
REQ-019 SHALL drive instr_rdata_o/data_rdata_o = mem_rdata_i unconditionally; only rvalid/err are gated.
REQ-020 SHALL update round-robin pointer only on a host grant; FIFO pointer arithmetic wraps modulo MaxOutstanding.

Reset
REQ-021 SHALL on rst_i clear FIFO (count 0), lock, protocol_err_o; round-robin pointer to DataFirstReset.
REQ-022 SHALL with rst_i high drive mem_req_o, all gnt, all rvalid, all err to 0.
REQ-023 SHALL treat reset mid-transaction as abandoning in-flight responses; rvalid after reset with empty FIFO obeys REQ-018.

Structure
REQ-024 SHALL place typedef mem_src_e (MemSrcInstr=1'b0, MemSrcData=1'b1) in ibex_pkg.
REQ-025 SHALL implement source FIFO as sub-module ibex_mem_src_fifo (depth parameter, push/pop/full/empty/head).
REQ-026 SHALL be implementable in 120-400 lines; no memories, no clock gating.

Verification
REQ-027 SHALL test: both req at cycle after reset, gnt every cycle -> data granted first, then instr, alternating; rvalids routed in grant order.
REQ-028 SHALL test: instr req addr 0x100, mem_gnt_i low 3 cycles, data_req_i rises cycle 1 -> mem_addr_o stays 0x100 until grant; data granted next.
REQ-029 SHALL test: MaxOutstanding=2, two grants, no rvalid -> mem_req_o 0 with requests pending; rvalid in cycle 3 -> mem_req_o still 0 that cycle, 1 next.
REQ-030 SHALL test: data write we=1 be=4'h3 granted, rvalid with mem_err_i=1 -> data_err_o=1, instr_err_o=0, instr_rvalid_o=0.
REQ-031 SHALL test: mem_rvalid_i pulse with empty FIFO -> no requester rvalid, protocol_err_o=1 held until rst_i.
REQ-032 SHALL test: rst_i asserted with 2 outstanding -> next cycle FIFO empty, mem_req_o 0, pointer favours data.
